// File: rtl/move_undo_stack_if.sv
// Board-write / undo signal bundle between game_logic and move_undo_stack.
// The master side is game_logic; the slave side is the undo stack.
interface move_undo_stack_if #(
    parameter int PTR_W   = 5,
    parameter int ADDR_W  = 6,
    parameter int PIECE_W = 4
);
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [PIECE_W-1:0] wr_piece;
    logic [PIECE_W-1:0] wr_old_piece;
    logic               wr_first;
    logic               undo_req;
    logic               clear;
    logic               board_we;
    logic [ADDR_W-1:0]  board_addr;
    logic [PIECE_W-1:0] board_piece;
    logic               busy;
    logic [PTR_W:0]     count;
    logic               empty;
    logic               full;
    logic               dropped;

    modport master (
        output wr_en, wr_addr, wr_piece, wr_old_piece, wr_first, undo_req, clear,
        input  board_we, board_addr, board_piece, busy, count, empty, full, dropped
    );

    modport slave (
        input  wr_en, wr_addr, wr_piece, wr_old_piece, wr_first, undo_req, clear,
        output board_we, board_addr, board_piece, busy, count, empty, full, dropped
    );
endinterface

// File: rtl/move_undo_stack.sv
// Move undo stack: forwards board writes with one cycle of latency, logs each
// write's previous contents in a ring-buffer LIFO, and on undo replays the old
// pieces newest-first until the first write of the most recent move is restored.
module move_undo_stack #(
    parameter int DEPTH   = 32,
    parameter int PTR_W   = 5,
    parameter int ADDR_W  = 6,
    parameter int PIECE_W = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    move_undo_stack_if.slave   bus
);
    localparam int ENTRY_W = ADDR_W + PIECE_W + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_UNDO = 1'b1;

    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ZERO = 0;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [0:0]         state;
    logic [PTR_W-1:0]   head;
    logic [PTR_W:0]     count;
    logic               dropped;
    logic [ENTRY_W-1:0] ram [DEPTH];

    logic               board_we_p1;
    logic [ADDR_W-1:0]  board_addr_p1;
    logic [PIECE_W-1:0] board_piece_p1;

    logic [PTR_W-1:0]   top_ptr;
    logic [ENTRY_W-1:0] top_entry;
    logic [ADDR_W-1:0]  pop_addr;
    logic [PIECE_W-1:0] pop_old;
    logic               pop_first;
    logic               last_pop;
    logic               push;

    // Newest entry sits just below head; it is read combinationally so a pop
    // can be turned into a board write in the same cycle.
    assign top_ptr   = head - PTR_ONE;
    assign top_entry = ram[top_ptr];
    assign pop_addr  = top_entry[ENTRY_W-1 -: ADDR_W];
    assign pop_old   = top_entry[PIECE_W:1];
    assign pop_first = top_entry[0];
    assign last_pop  = pop_first || (count == CNT_ONE);

    // Writes are only logged while idle; during undo they are dropped.
    assign push = !RESET && !bus.clear && (state == ST_IDLE) && bus.wr_en;

    // Entry storage: full ring overwrites the oldest slot, no reset needed.
    always_ff @(posedge CLK) begin
        if (push) begin
            ram[head] <= {bus.wr_addr, bus.wr_old_piece, bus.wr_first};
        end
    end

    // Control state, history pointers and the registered board write port.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= ST_IDLE;
            head           <= '0;
            count          <= '0;
            dropped        <= 1'b0;
            board_we_p1    <= 1'b0;
            board_addr_p1  <= '0;
            board_piece_p1 <= '0;
        end else if (bus.clear) begin
            state       <= ST_IDLE;
            head        <= '0;
            count       <= '0;
            dropped     <= 1'b0;
            board_we_p1 <= 1'b0;
        end else if (state == ST_IDLE) begin
            board_we_p1 <= 1'b0;
            if (bus.wr_en) begin
                // A write wins over a simultaneous undo request.
                board_we_p1    <= 1'b1;
                board_addr_p1  <= bus.wr_addr;
                board_piece_p1 <= bus.wr_piece;
                head           <= head + PTR_ONE;
                if (count != CNT_FULL) begin
                    count <= count + CNT_ONE;
                end
            end else if (bus.undo_req && (count != CNT_ZERO)) begin
                state <= ST_UNDO;
            end
        end else begin
            if (bus.wr_en) begin
                dropped <= 1'b1;
            end
            board_we_p1    <= 1'b1;
            board_addr_p1  <= pop_addr;
            board_piece_p1 <= pop_old;
            head           <= top_ptr;
            count          <= count - CNT_ONE;
            if (last_pop) begin
                state <= ST_IDLE;
            end
        end
    end

    assign bus.board_we    = board_we_p1;
    assign bus.board_addr  = board_addr_p1;
    assign bus.board_piece = board_piece_p1;
    assign bus.busy        = (state == ST_UNDO);
    assign bus.count       = count;
    assign bus.empty       = (count == CNT_ZERO);
    assign bus.full        = (count == CNT_FULL);
    assign bus.dropped     = dropped;
endmodule
